fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 142 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer (IDLE/REQ/HOLD/FLUSH) with redirect handling.
// Optional macro PC_ALIGN_CHECK_EN: misaligned redirects vector to EXC_VECTOR and pulse misalign_exc.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc,
    output logic        misalign_exc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        FLUSH
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic [31:0] flush_addr;
    logic [31:0] flush_addr_next;
    logic [31:0] instr_next;
    logic [31:0] instr_pc_next;
    logic        valid_next;
    logic [31:0] target;
    logic        target_misaligned;

`ifdef PC_ALIGN_CHECK_EN
    always_comb begin
        target_misaligned = (redirect_target[1:0] != 2'b00);
        target            = target_misaligned ? EXC_VECTOR : redirect_target;
    end
`else
    // Low address bits are simply dropped; the exception vector is never taken.
    logic unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;

    always_comb begin
        target_misaligned = 1'b0;
        target            = redirect_target & 32'hFFFF_FFFC;
    end
`endif

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        flush_addr_next = flush_addr;
        instr_next      = instr;
        instr_pc_next   = instr_pc;
        valid_next      = instr_valid;

        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (redirect_valid) begin
                    // Without an ack the bus transfer is still open; it must finish at the old address.
                    if (!imem_ack) begin
                        state_next      = FLUSH;
                        flush_addr_next = pc;
                    end
                end else if (imem_ack) begin
                    instr_next    = imem_rdata;
                    instr_pc_next = pc;
                    valid_next    = 1'b1;
                    pc_next       = pc + 32'd4;
                    state_next    = stall ? HOLD : REQ;
                end else if (instr_valid && !stall) begin
                    valid_next = 1'b0;
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_next = REQ;
                    valid_next = 1'b0;
                end
            end
            FLUSH: begin
                if (imem_ack) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        if (redirect_valid) begin
            pc_next    = target;
            valid_next = 1'b0;
            if (state == HOLD) begin
                state_next = REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            flush_addr  <= RESET_VECTOR;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            flush_addr  <= flush_addr_next;
            instr       <= instr_next;
            instr_pc    <= instr_pc_next;
            instr_valid <= valid_next;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= redirect_valid && target_misaligned;
        end
    end
`else
    logic unused_misaligned;
    assign unused_misaligned = target_misaligned;
    assign misalign_exc      = 1'b0;
`endif

    assign imem_req  = (state == REQ) || (state == FLUSH);
    assign imem_addr = (state == FLUSH) ? flush_addr : pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized bench for fetch_sequencer against a transaction-level model.
module tb_fetch_sequencer;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] EV = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        misalign_exc;

    int vectors = 0;
    int miscompares = 0;

    // Model: a fetch is either wanted (new data accepted), being drained (data dropped),
    // or parked behind a stalled decode.
    bit          m_started;
    bit          m_wanted;
    bit          m_draining;
    bit          m_parked;
    bit          m_valid;
    bit          m_exc;
    logic [31:0] m_pc;
    logic [31:0] m_drain_addr;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    fetch_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EV)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .pc(pc),
        .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_wanted = 0; m_draining = 0; m_parked = 0;
        m_valid = 0; m_exc = 0; m_pc = RV; m_drain_addr = RV;
        m_instr = 32'h0; m_ipc = 32'h0;
    endtask

    function automatic logic [31:0] landing(input logic [31:0] t);
        if (ALIGN) return (t % 4 != 0) ? EV : t;
        return t - (t % 4);
    endfunction

    task automatic model_step();
        m_exc = ALIGN && redirect_valid && (redirect_target % 4 != 0);
        if (!m_started) begin
            m_started = 1;
            m_wanted  = 1;
            if (redirect_valid) begin
                m_pc = landing(redirect_target);
                m_valid = 0;
            end
        end else if (redirect_valid) begin
            if (m_wanted && !imem_ack) begin
                m_draining   = 1;
                m_wanted     = 0;
                m_drain_addr = m_pc;
            end else if (!(m_draining && !imem_ack)) begin
                m_draining = 0;
                m_wanted   = 1;
            end
            m_parked = 0;
            m_pc     = landing(redirect_target);
            m_valid  = 0;
        end else if (m_draining) begin
            if (imem_ack) begin
                m_draining = 0;
                m_wanted   = 1;
            end
        end else if (m_parked) begin
            if (!stall) begin
                m_parked = 0;
                m_wanted = 1;
                m_valid  = 0;
            end
        end else if (imem_ack) begin
            m_instr = imem_rdata;
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 32'd4;
            if (stall) begin
                m_parked = 1;
                m_wanted = 0;
            end
        end else if (m_valid && !stall) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("imem_req", {31'h0, imem_req}, {31'h0, m_wanted || m_draining});
        check("imem_addr", imem_addr, m_draining ? m_drain_addr : m_pc);
        check("pc", pc, m_pc);
        check("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
        check("misalign_exc", {31'h0, misalign_exc}, {31'h0, m_exc});
        if (m_valid) begin
            check("instr", instr, m_instr);
            check("instr_pc", instr_pc, m_ipc);
        end
    endtask

    // Called at a falling edge: drive, take the rising edge, update the model, check at next fall.
    task automatic drive(input bit s, input bit rv, input logic [31:0] rt,
                         input bit ack, input logic [31:0] rd);
        stall = s;
        redirect_valid = rv;
        redirect_target = rt;
        imem_ack = ack;
        imem_rdata = rd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0100;
            1: return 32'h0000_0102;
            2: return 32'hFFFF_FFFC;
            3: return 32'hFFFF_FFF9;
            4: return $urandom() & 32'hFFFF_FFFC;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        check("rst_imem_req", {31'h0, imem_req}, 32'h0);
        check("rst_pc", pc, RV);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Sequential fetch 0,4,8
        drive(0, 0, 0, 0, 0);
        check("seq_addr0", imem_addr, 32'h0);
        drive(0, 0, 0, 1, 32'hA000_0000);
        check("seq_addr4", imem_addr, 32'h4);
        check("seq_ipc0", instr_pc, 32'h0);
        drive(0, 0, 0, 1, 32'hA000_0004);
        check("seq_addr8", imem_addr, 32'h8);
        // Redirect while the request to 8 is still open
        drive(0, 1, 32'h0000_0100, 0, 0);
        check("flush_addr", imem_addr, 32'h8);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'hDEAD_BEEF);
        check("flush_done_addr", imem_addr, 32'h100);
        check("flush_valid", {31'h0, instr_valid}, 32'h0);
        // Redirect coincident with ack
        drive(0, 1, 32'h0000_0200, 1, 32'hBAD0_BAD0);
        check("same_cycle_addr", imem_addr, 32'h200);
        // Stall hold
        drive(1, 0, 0, 1, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1, $urandom());
            check("hold_instr", instr, 32'h1234_5678);
            check("hold_req", {31'h0, imem_req}, 32'h0);
        end
        drive(0, 0, 0, 0, 0);
        check("resume_req", {31'h0, imem_req}, 32'h1);
        // Wrap
        drive(0, 1, 32'hFFFF_FFFC, 1, 0);
        drive(0, 0, 0, 1, 32'hC0DE_0000);
        check("wrap_addr", imem_addr, 32'h0);
        // Misaligned redirect
        drive(0, 1, 32'h0000_0102, 1, 0);
        check("misalign_addr", imem_addr, ALIGN ? 32'h80 : 32'h100);
        check("misalign_pulse", {31'h0, misalign_exc}, {31'h0, ALIGN});
        drive(0, 0, 0, 0, 0);
        check("misalign_clear", {31'h0, misalign_exc}, 32'h0);

        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) begin
                #2 rst = 1'b1;
                #1;
                check("async_rst_req", {31'h0, imem_req}, 32'h0);
                check("async_rst_pc", pc, RV);
                check("async_rst_valid", {31'h0, instr_valid}, 32'h0);
                check("async_rst_exc", {31'h0, misalign_exc}, 32'h0);
                imem_ack = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                model_reset();
            end
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, pick_target(),
                  $urandom_range(0, 1) == 1, $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
